// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and types for the read/write port arbiters.
package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int DATA_W = 64;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first valid index at or after ptr, as one-hot and encoded index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [2*N-1:0] rot_dbl;
  logic [2*N-1:0] spread;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_grant;
  // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
  always_comb begin
    rot_dbl = {valid, valid} >> ptr;
    rot = rot_dbl[N-1:0];
    rot_grant = rot & (~rot + 1'b1);
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx = W'((int'(ptr) + k) % N);
    spread = {{N{1'b0}}, rot_grant} << ptr;
    grant = spread[N-1:0] | spread[2*N-1:N];
    any = |valid;
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin sharing of the register-file read port with a one-cycle registered response.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rd_sel,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (grant_idx),
    .any  (any_grant)
  );
  assign req_ready = reset_n ? grant : '0;
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) rd_sel = req_addr[i*ADDR_W +: ADDR_W];
  end
  // rsp_data only loads on an accept, so it holds through idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= grant;
      if (any_grant) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rsp_data <= rd_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: random and directed requesters against a scoreboarded reference of the read arbiter.
module tb_regfile_read_arbiter;
  localparam int N = 4;
  localparam int AW = 5;
  localparam int DW = 64;
  logic clk = 0;
  logic reset_n = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0] req_ready;
  logic [AW-1:0] rd_sel;
  logic [DW-1:0] rd_data;
  logic [N-1:0] rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] mem [32];
  typedef struct {
    logic [N-1:0]  oh;
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ptr = 0;
  logic [N-1:0] v = '0;
  logic [AW-1:0] a [N];
  int waitc [N];
  logic [DW-1:0] last_data = '0;
  regfile_read_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rd_sel(rd_sel), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );
  assign rd_data = mem[rd_sel];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // One cycle: drive requesters, predict the grant from the round-robin rule, queue the response.
  task automatic step();
    int g;
    logic [N-1:0] eoh;
    logic [AW-1:0] esel;
    @(negedge clk);
    req_valid = v;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = a[i];
    #1;
    g = -1;
    if (reset_n)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    eoh = (g < 0) ? '0 : (N'(1) << g);
    esel = (g < 0) ? '0 : a[g];
    chk("req_ready", 64'(req_ready), 64'(eoh));
    chk("rd_sel", 64'(rd_sel), 64'(esel));
    if (g >= 0) begin
      chk("fair_wait", 64'(waitc[g] <= N - 1), 64'd1);
      q.push_back('{eoh, mem[a[g]], cyc + 1});
      ptr = (g + 1) % N;
      v[g] = 1'b0;
    end
    for (int i = 0; i < N; i++) waitc[i] = (reset_n && v[i]) ? waitc[i] + 1 : 0;
  endtask
  task automatic release_reset();
    @(posedge clk);
    #2 reset_n = 1;
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rsp_valid !== '0) begin
      if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e.oh));
        chk("rsp_data", rsp_data, e.d);
      end
      last_data = rsp_data;
    end else begin
      chk("rsp_hold", rsp_data, last_data);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("rsp_missing", 64'(rsp_valid), 64'(q[0].oh));
        q.delete(0);
      end
    end
  end
  initial begin
    for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom};
    mem[7] = 64'hDEAD_BEEF_0000_0007;
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(i + 1);
      waitc[i] = 0;
    end
    #1 reset_n = 0;
    v = '1;
    repeat (3) begin
      step();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
    end
    release_reset();
    step();
    chk("first_grant", 64'(req_ready), 64'h1);
    for (int c = 0; c < 8; c++) begin
      v = '1;
      step();
      chk("rr_order", 64'(req_ready), 64'(1 << ((c + 1) % N)));
    end
    v = '0;
    repeat (2) step();
    v = 4'b0100;
    a[2] = 5'd7;
    step();
    chk("single_sel", 64'(rd_sel), 64'd7);
    @(posedge clk);
    #2;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("single_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0007);
    v = 4'b0101;
    a[0] = 5'd9;
    a[2] = 5'd10;
    step();
    chk("wrap_grant", 64'(req_ready), 64'h1);
    step();
    chk("skip_grant", 64'(req_ready), 64'h4);
    repeat (2) step();
    v = '1;
    step();
    chk("idle_ptr_hold", 64'(req_ready), 64'h8);
    v = 4'b0110;
    step();
    @(posedge clk);
    #3 reset_n = 0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    q.delete();
    ptr = 0;
    last_data = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    repeat (2) step();
    release_reset();
    v = '1;
    step();
    chk("post_rst_grant", 64'(req_ready), 64'h1);
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 31));
        end
      step();
    end
    v = '0;
    repeat (3) step();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
